nn_layer_sequencer: RTL and testbench

//  FSM that sequences the shared MAC datapath of the two-layer MNIST MLP (784->N1->10).
//  Per neuron: clear/bias-load, stream weight+activation read addresses, drain pipeline, write result.

---
 rtl/nn_layer_sequencer_if.sv | 11 +
 rtl/nn_layer_sequencer.sv | 77 +++++++
 tb/tb_nn_layer_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if: start/stall control in, ROM/RAM/MAC sequencing strobes and addresses out
interface nn_layer_sequencer_if #(parameter int ADDR_W = 16);
  logic start, stall, busy, done, layer, act_wr_en, relu_en, mac_clr, mac_en;
  logic [ADDR_W-1:0] w_addr, b_addr, act_rd_addr, act_wr_addr;
  modport master (output start, stall,
                  input busy, done, layer, w_addr, b_addr, act_rd_addr, act_wr_addr,
                        act_wr_en, relu_en, mac_clr, mac_en);
  modport slave (input start, stall,
                 output busy, done, layer, w_addr, b_addr, act_rd_addr, act_wr_addr,
                        act_wr_en, relu_en, mac_clr, mac_en);
endinterface

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: per-neuron clear/issue/drain/write sequencing of the shared MAC for a 2-layer MLP
module nn_layer_sequencer #(
  parameter int IN0 = 784,
  parameter int N1 = 32,
  parameter int N2 = 10,
  parameter int MAC_LAT = 2,
  parameter int ADDR_W = 16
) (
  input logic clk,
  input logic rst,
  nn_layer_sequencer_if.slave sq
);
  localparam logic [2:0] IDLE = 3'd0, CLR = 3'd1, ISSUE = 3'd2, DRAIN = 3'd3, WRITE = 3'd4, DONE = 3'd5;
  if (longint'(IN0) * N1 + longint'(N1) * N2 >= (longint'(1) << ADDR_W) || MAC_LAT < 1) begin : g_chk
    $error("nn_layer_sequencer: weight count exceeds ADDR_W or MAC_LAT < 1");
  end
  logic [2:0] state;
  logic layer, mac_q, k_last, n_last;
  logic [ADDR_W-1:0] in_cnt, d_cnt, neuron, w;
  assign k_last = in_cnt == (layer ? ADDR_W'(N1 - 1) : ADDR_W'(IN0 - 1));
  assign n_last = neuron == (layer ? ADDR_W'(N2 - 1) : ADDR_W'(N1 - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      layer <= 1'b0;
      mac_q <= 1'b0;
      in_cnt <= '0;
      d_cnt <= '0;
      neuron <= '0;
      w <= '0;
    end else if (!sq.stall) begin
      mac_q <= state == ISSUE;
      case (state)
        IDLE: if (sq.start) begin
          state <= CLR;
          layer <= 1'b0;
          neuron <= '0;
          w <= '0;
        end
        CLR: begin
          state <= ISSUE;
          in_cnt <= '0;
        end
        ISSUE: if (k_last) begin
          state <= DRAIN;
          in_cnt <= '0;
          d_cnt <= '0;
        end else begin
          in_cnt <= in_cnt + 1'b1;
          w <= w + 1'b1;
        end
        DRAIN: if (d_cnt == ADDR_W'(MAC_LAT)) state <= WRITE;
               else d_cnt <= d_cnt + 1'b1;
        WRITE: begin
          // w_addr runs on across neurons so weights stay linear over both layers
          state <= (n_last && layer) ? DONE : CLR;
          if (!(n_last && layer)) w <= w + 1'b1;
          neuron <= n_last ? '0 : neuron + 1'b1;
          if (n_last) layer <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign sq.busy = state != IDLE && state != DONE;
  assign sq.done = state == DONE;
  assign sq.layer = layer;
  assign sq.w_addr = w;
  assign sq.b_addr = layer ? neuron + ADDR_W'(N1) : neuron;
  assign sq.act_rd_addr = in_cnt;
  assign sq.act_wr_addr = neuron;
  assign sq.act_wr_en = state == WRITE;
  assign sq.relu_en = state == WRITE && !layer;
  assign sq.mac_clr = state == CLR;
  assign sq.mac_en = mac_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: table vectors plus schedule-model checks under random stall/start noise
module tb_nn_layer_sequencer;
  localparam int IN0 = 4, N1 = 2, N2 = 3, ML = 1, AW = 16;
  localparam int P0 = 3 + IN0 + ML, P1 = 3 + N1 + ML, TOTAL = N1 * P0 + N2 * P1;
  logic clk = 0, rst = 1;
  nn_layer_sequencer_if #(.ADDR_W(AW)) bus ();
  nn_layer_sequencer #(.IN0(IN0), .N1(N1), .N2(N2), .MAC_LAT(ML), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .sq(bus));
  always #5 clk = ~clk;
  typedef struct {logic busy, done, clr, men, wen, relu, layer; int w, b, rd, wa, ph;} exp_t;
  typedef struct {bit st, sl; logic busy, clr, men, wen; int w;} vec_t;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc = 0, t = 0, mc = 0, wc = 0, sc = 0;
  bit act = 0;
  task automatic chk(input string nm, input longint a, input longint e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s @cyc %0d t %0d: got %0d expected %0d", nm, cyc, t, a, e);
    end
  endtask
  // expected outputs from the neuron schedule: t counts unstalled cycles since the accepting edge
  function automatic exp_t model(bit a, int tt);
    exp_t e = '{default: 0};
    int p, q, per, k, n, o;
    bit ly;
    if (!a) return e;
    if (tt == TOTAL + 1) begin
      e.done = 1; e.ph = 5;
      return e;
    end
    p = tt - 1;
    ly = p >= N1 * P0;
    q = ly ? p - N1 * P0 : p;
    per = ly ? P1 : P0;
    k = ly ? N1 : IN0;
    n = q / per;
    o = q % per;
    e.busy = 1; e.layer = ly; e.b = ly ? N1 + n : n; e.wa = n;
    e.rd = o - 1;
    e.w = (ly ? N1 * IN0 + n * N1 : n * IN0) + o - 1;
    e.clr = o == 0;
    e.men = o >= 2 && o <= k + 1;
    e.wen = o == per - 1;
    e.relu = e.wen && !ly;
    e.ph = o == 0 ? 1 : o <= k ? 2 : o == per - 1 ? 4 : 3;
    return e;
  endfunction
  task automatic step(input bit st, input bit sl);
    exp_t e;
    bus.start = st;
    bus.stall = sl;
    @(posedge clk);
    #1;
    cyc++;
    bus.start = 0;
    if (!sl) begin
      if (act) begin
        if (t == TOTAL + 1) begin act = 0; t = 0; end
        else t++;
      end else if (st) begin
        act = 1; t = 1; acc = cyc;
      end
      mc += int'(bus.mac_en);
      wc += int'(bus.act_wr_en);
    end
    e = model(act, t);
    chk("busy", bus.busy, e.busy);
    chk("done", bus.done, e.done);
    chk("mac_clr", bus.mac_clr, e.clr);
    chk("mac_en", bus.mac_en, e.men);
    chk("act_wr_en", bus.act_wr_en, e.wen);
    chk("relu_en", bus.relu_en, e.relu);
    if (e.busy) chk("layer", bus.layer, e.layer);
    if (e.ph == 1) chk("b_addr", bus.b_addr, e.b);
    if (e.ph == 2) begin
      chk("w_addr", bus.w_addr, e.w);
      chk("act_rd_addr", bus.act_rd_addr, e.rd);
    end
    if (e.ph == 4) chk("act_wr_addr", bus.act_wr_addr, e.wa);
  endtask
  task automatic chk_zero();
    chk("rst_busy", bus.busy, 0); chk("rst_done", bus.done, 0); chk("rst_layer", bus.layer, 0);
    chk("rst_w_addr", bus.w_addr, 0); chk("rst_b_addr", bus.b_addr, 0);
    chk("rst_act_rd_addr", bus.act_rd_addr, 0); chk("rst_act_wr_addr", bus.act_wr_addr, 0);
    chk("rst_act_wr_en", bus.act_wr_en, 0); chk("rst_relu_en", bus.relu_en, 0);
    chk("rst_mac_clr", bus.mac_clr, 0); chk("rst_mac_en", bus.mac_en, 0);
  endtask
  task automatic run(input int s_at, input int s_n, input bit rnd, output int len);
    bit got = 0, sl, st;
    int i = 0;
    len = 0; mc = 0; wc = 0; sc = 0;
    step(1, 0);
    while (act && i < 400) begin
      sl = (i >= s_at && i < s_at + s_n) || (rnd && $urandom_range(0, 3) == 0);
      st = rnd && $urandom_range(0, 1) == 1;
      step(st, sl);
      if (!got) begin
        if (sl) sc++;
        else if (bus.done) begin got = 1; len = cyc - acc + 1; end
      end
      i++;
    end
    chk("run_terminated", int'(act), 0);
  endtask
  vec_t vecs[10];
  int len;
  initial begin
    vecs[0] = '{1, 0, 1, 1, 0, 0, -1};
    vecs[1] = '{0, 0, 1, 0, 0, 0, 0};
    vecs[2] = '{0, 0, 1, 0, 1, 0, 1};
    vecs[3] = '{0, 1, 1, 0, 1, 0, 1};
    vecs[4] = '{0, 0, 1, 0, 1, 0, 2};
    vecs[5] = '{0, 0, 1, 0, 1, 0, 3};
    vecs[6] = '{0, 0, 1, 0, 1, 0, -1};
    vecs[7] = '{0, 0, 1, 0, 0, 0, -1};
    vecs[8] = '{0, 0, 1, 0, 0, 1, -1};
    vecs[9] = '{0, 0, 1, 1, 0, 0, -1};
    bus.start = 0;
    bus.stall = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero();
    rst = 0;
    step(0, 0);
    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].sl);
      chk("tv_busy", bus.busy, vecs[i].busy);
      chk("tv_mac_clr", bus.mac_clr, vecs[i].clr);
      chk("tv_mac_en", bus.mac_en, vecs[i].men);
      chk("tv_act_wr_en", bus.act_wr_en, vecs[i].wen);
      if (vecs[i].w >= 0) chk("tv_w_addr", bus.w_addr, vecs[i].w);
    end
    for (int i = 0; i < 100 && act; i++) step(0, 0);
    chk("tv_run_end", int'(act), 0);
    run(0, 0, 0, len);
    chk("len_plain", len, 35);
    chk("mac_en_count", mc, 14);
    chk("wr_en_count", wc, 5);
    chk("final_w_addr", bus.w_addr, N1 * IN0 + N2 * N1 - 1);
    run(2, 3, 0, len);
    chk("len_stall3", len, 38);
    chk("mac_en_count_stall", mc, 14);
    repeat (3) begin
      run(-1, 0, 1, len);
      chk("len_random", len, 35 + sc);
      chk("mac_en_count_rnd", mc, 14);
      chk("wr_en_count_rnd", wc, 5);
    end
    step(1, 0);
    repeat (20) step(0, 0);
    chk("mid_run_layer", bus.layer, 1);
    #2 rst = 1;
    #1;
    chk_zero();
    act = 0;
    t = 0;
    @(posedge clk);
    #1 rst = 0;
    run(0, 0, 0, len);
    chk("len_after_rst", len, 35);
    chk("mac_en_count_rst", mc, 14);
    chk("wr_en_count_rst", wc, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
